color_normalizer: RTL

Responder side of the color sequencer's calculate handshake (`calc_EN` / `calc_reset` / `calc_done`). It takes the raw frequency of one filtered photodiode channel and the clear-channel frequency. It computes the channel's share of the clear reading as an integer percentage, `min(SCALE, color_raw*SCALE/clear)`, using a multi-cycle restoring divider. The result is returned on `color` with `calc_done` held high until the sequencer acknowledges. It sits between the frequency counter / color sequencer and the color-compare logic.

---
 rtl/color_normalizer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/color_normalizer.sv
// Color channel normalizer: min(SCALE, color_raw*SCALE/clear)
// computed by a bit-serial restoring divider behind a level handshake.
module color_normalizer #(
    parameter int unsigned SCALE = 100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        calc_EN,
    input  logic        calc_reset,
    input  logic [15:0] color_raw,
    input  logic [15:0] clear,
    output logic [15:0] color,
    output logic        calc_done,
    output logic        busy
);

    localparam logic [22:0] SCALE_Q = 23'(SCALE);
    localparam logic [15:0] SCALE_C = 16'(SCALE);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        DONE
    } state_t;

    state_t      state;
    logic [22:0] num;
    logic [15:0] den;
    logic [16:0] rem;
    logic [22:0] q;
    logic [4:0]  cnt;

    logic [22:0] num_in;
    logic [16:0] rem_sh;
    logic [16:0] rem_sub;
    logic [16:0] rem_next;
    logic [22:0] q_next;
    logic        fits;

    assign num_in = 23'(color_raw) * SCALE_Q;

    // One restoring-division step: shift in the next numerator bit, subtract if it fits.
    always_comb begin
        rem_sh   = 17'({rem, num[cnt]});
        rem_sub  = rem_sh - {1'b0, den};
        fits     = (rem_sh >= {1'b0, den});
        rem_next = fits ? rem_sub : rem_sh;
        q_next   = q;
        if (fits) begin
            q_next[cnt] = 1'b1;
        end
    end

    // Handshake FSM and divider datapath; outputs are registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            num       <= '0;
            den       <= '0;
            rem       <= '0;
            q         <= '0;
            cnt       <= '0;
            color     <= '0;
            calc_done <= 1'b0;
            busy      <= 1'b0;
        end else if (calc_reset) begin
            state     <= IDLE;
            calc_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (calc_EN) begin
                        num   <= num_in;
                        den   <= clear;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (den == 16'd0) begin
                        color     <= '0;
                        calc_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        rem   <= '0;
                        q     <= '0;
                        cnt   <= 5'd22;
                        state <= DIV;
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    q   <= q_next;
                    if (cnt == 5'd0) begin
                        color     <= (q_next > SCALE_Q) ? SCALE_C
                                                        : q_next[15:0];
                        calc_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                DONE: begin
                    if (!calc_EN) begin
                        calc_done <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
